// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction-bus widths, boot/exception vectors and
// the fetch controller state encoding.
package cpu_defs;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_VEC  = 32'hbfc00380;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding transaction on the req/addr_ok/data_ok
// instruction bus, with redirect-driven cancellation of stale responses.
module inst_fetch_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_req,
  input  logic              redirect,
  input  logic              stall,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              complete
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              cancel_q, cancel_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      inst_q   <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    cancel_d = cancel_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_req && !redirect) begin
          if (fetch_pc[1:0] == 2'b00) begin
            state_d = S_REQ;
            addr_d  = fetch_pc;
          end else begin
            // Misaligned PC: hand back a null word; the IF stage raises AdEL.
            state_d = S_DONE;
            inst_d  = '0;
          end
        end
      end
      S_REQ: begin
        if (redirect) cancel_d = 1'b1;
        if (inst_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) cancel_d = 1'b1;
        if (inst_data_ok) begin
          if (cancel_q || redirect) begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
          end else begin
            state_d = S_DONE;
            inst_d  = inst_rdata;
          end
        end
      end
      S_DONE: begin
        if (redirect || !stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inst_req   = (state_q == S_REQ);
  assign complete   = (state_q == S_DONE);
  assign inst_addr  = addr_q;
  assign fetch_inst = inst_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed + randomized bench for inst_fetch_ctrl; the expected outcome of each
// fetch is derived from its bus timing and redirect position.
module tb_inst_fetch_ctrl;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] fetch_pc;
  logic        fetch_req;
  logic        redirect;
  logic        stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] fetch_inst;
  logic        complete;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_inst = 32'h0;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .fetch_pc(fetch_pc), .fetch_req(fetch_req),
    .redirect(redirect), .stall(stall), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .fetch_inst(fetch_inst), .complete(complete)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch. Cycle 0 presents the PC; an aligned request is on the bus from
  // cycle 1, addr_ok comes ad cycles later, data_ok dd+1 cycles after that.
  // redir_at names the cycle carrying redirect (none if it never matches).
  task automatic run_fetch(input logic [31:0] pc, input int ad, input int dd,
                           input int redir_at, input logic [31:0] rdata,
                           input int stall_n, input bit done_redir);
    int  a_cyc, d_cyc;
    bit  stale;
    stale = 1'b0;
    @(negedge clk);
    chk("idle_req", inst_req, 1'b0);
    chk("idle_cpl", complete, 1'b0);
    fetch_req = 1'b1; fetch_pc = pc; redirect = 1'b0; stall = 1'b0;
    if (pc[1:0] != 2'b00) begin
      @(negedge clk);
      fetch_req = 1'b0;
      chk("mis_req", inst_req, 1'b0);
      chk("mis_cpl", complete, 1'b1);
      chk("mis_inst", fetch_inst, 32'h0);
      last_inst = 32'h0;
    end else begin
      a_cyc = 1 + ad;
      d_cyc = a_cyc + 1 + dd;
      for (int t = 1; t <= d_cyc; t++) begin
        @(negedge clk);
        fetch_req = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; redirect = 1'b0;
        inst_rdata = $urandom;
        if (t <= a_cyc) begin
          chk("req_hi", inst_req, 1'b1);
          chk("req_addr", inst_addr, pc);
        end else begin
          chk("req_lo", inst_req, 1'b0);
        end
        chk("cpl_early", complete, 1'b0);
        if (t == a_cyc) inst_addr_ok = 1'b1;
        if (t == d_cyc) begin inst_data_ok = 1'b1; inst_rdata = rdata; end
        if (t == redir_at) begin redirect = 1'b1; stale = 1'b1; end
      end
      @(negedge clk);
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; redirect = 1'b0;
      if (stale) begin
        chk("stale_cpl", complete, 1'b0);
        chk("stale_req", inst_req, 1'b0);
        chk("stale_inst", fetch_inst, last_inst);
        $display("txn pc=%h ad=%0d dd=%0d redirect_cycle=%0d -> discarded", pc, ad, dd, redir_at);
        return;
      end
      chk("cpl", complete, 1'b1);
      chk("inst", fetch_inst, rdata);
      last_inst = rdata;
    end
    if (done_redir) begin
      stall = 1'b1; redirect = 1'b1;
      @(negedge clk);
      redirect = 1'b0; stall = 1'b0;
    end else begin
      for (int s = 0; s < stall_n; s++) begin
        stall = 1'b1;
        @(negedge clk);
        chk("hold_cpl", complete, 1'b1);
        chk("hold_inst", fetch_inst, last_inst);
        chk("hold_req", inst_req, 1'b0);
      end
      stall = 1'b0;
      @(negedge clk);
    end
    chk("end_cpl", complete, 1'b0);
    chk("end_inst", fetch_inst, last_inst);
    $display("txn pc=%h ad=%0d dd=%0d stall=%0d done_redirect=%0d -> delivered %h",
             pc, ad, dd, stall_n, done_redir, last_inst);
  endtask

  initial begin
    resetn = 1'b0; fetch_pc = 32'h0; fetch_req = 1'b0; redirect = 1'b0; stall = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", inst_req, 1'b0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_inst", fetch_inst, 32'h0);
    chk("rst_cpl", complete, 1'b0);
    resetn = 1'b1;

    run_fetch(RESET_PC, 0, 0, 0, 32'h3c1d8000, 0, 1'b0);
    chk("aligned_addr", inst_addr, RESET_PC);
    run_fetch(32'hbfc00004, 3, 3, 0, 32'h24080001, 0, 1'b0);
    run_fetch(32'hbfc00008, 0, 0, 2, 32'hdeadbeef, 0, 1'b0);
    run_fetch(EXC_VEC, 0, 1, 0, 32'h401a6800, 0, 1'b0);
    run_fetch(32'hbfc0000c, 1, 2, 2, 32'h11111111, 0, 1'b0);
    run_fetch(32'hbfc00010, 0, 2, 4, 32'h22222222, 0, 1'b0);
    run_fetch(32'hbfc00014, 2, 0, 1, 32'h33333333, 0, 1'b0);
    run_fetch(32'hbfc00002, 0, 0, 0, 32'h0, 0, 1'b0);
    run_fetch(32'hbfc00018, 1, 1, 0, 32'h8c880000, 5, 1'b0);
    run_fetch(32'hbfc0001c, 0, 0, 0, 32'h55aa55aa, 0, 1'b1);

    // Asynchronous reset in the middle of a WAIT.
    @(negedge clk);
    fetch_req = 1'b1; fetch_pc = 32'hbfc00020;
    @(negedge clk);
    fetch_req = 1'b0; inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    chk("wait_req", inst_req, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_req", inst_req, 1'b0);
    chk("arst_addr", inst_addr, 32'h0);
    chk("arst_inst", fetch_inst, 32'h0);
    chk("arst_cpl", complete, 1'b0);
    last_inst = 32'h0;
    @(negedge clk);
    resetn = 1'b1;
    $display("txn reset pulse during WAIT -> outputs cleared");
    run_fetch(RESET_PC, 0, 0, 0, 32'h3c1d8000, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] pc;
      pc = 32'hbfc00000 | ({20'h0, 12'($urandom)} & 32'h00000ffc);
      if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      run_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 0,
                $urandom, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
